// File: rtl/paralelo_serial_param.sv
// paralelo_serial_param
// Parallel-to-serial converter with a one-word holding buffer. A continuous
// serial stream is produced on bit_tick strobes. At every word boundary the
// buffered producer word is sent if one is waiting; otherwise IDLE_WORD is sent.
module paralelo_serial_param #(
  parameter int               WIDTH     = 10,
  parameter int               MSB_FIRST = 1,
  parameter logic [WIDTH-1:0] IDLE_WORD = 10'h0FA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             bit_tick,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             word_start,
  output logic             sending_data
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // OFF until the first boundary after reset, then IDLE or DATA per word.
  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_IDLE = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_buf;
  logic             r_buf_full;
  logic             r_data_ready;
  // Holds only the bits still to be sent. The bit currently on serial_out has
  // already been moved out into r_serial_out.
  logic [WIDTH-1:0] r_shifter;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_serial_out;
  logic             r_word_start;

  logic             w_accept;
  logic             w_boundary;
  logic             w_load;
  logic             w_buf_full_next;
  logic [WIDTH-1:0] w_load_word;
  logic [WIDTH-1:0] w_load_rest;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shift_next;

  // Accept and load are mutually exclusive because they need opposite buf_full
  // values. Therefore the buffer never bypasses directly into the shifter.
  assign w_accept        = data_valid & r_data_ready;
  assign w_boundary      = (r_bit_cnt == CNT_LAST);
  assign w_load          = bit_tick & w_boundary & r_buf_full;
  assign w_buf_full_next = w_accept | (r_buf_full & ~w_load);
  assign w_load_word     = r_buf_full ? r_buf : IDLE_WORD;

  // Bit-order dependent selection of the first bit, the remainder and the shift.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_first_bit  = w_load_word[WIDTH-1];
      assign w_load_rest  = {w_load_word[WIDTH-2:0], 1'b0};
      assign w_next_bit   = r_shifter[WIDTH-1];
      assign w_shift_next = {r_shifter[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_first_bit  = w_load_word[0];
      assign w_load_rest  = {1'b0, w_load_word[WIDTH-1:1]};
      assign w_next_bit   = r_shifter[0];
      assign w_shift_next = {1'b0, r_shifter[WIDTH-1:1]};
    end
  endgenerate

  // Reset, handshake buffer, shifter, bit counter and word state in one process.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_OFF;
      r_buf        <= '0;
      r_buf_full   <= 1'b0;
      r_data_ready <= 1'b1;
      r_shifter    <= '0;
      r_bit_cnt    <= CNT_LAST;
      r_serial_out <= 1'b0;
      r_word_start <= 1'b0;
    end else if (enb) begin
      r_word_start <= 1'b0;
      if (w_accept) begin
        r_buf <= data_in;
      end
      r_buf_full   <= w_buf_full_next;
      r_data_ready <= ~w_buf_full_next;
      if (bit_tick) begin
        if (w_boundary) begin
          r_bit_cnt    <= '0;
          r_shifter    <= w_load_rest;
          r_serial_out <= w_first_bit;
          r_word_start <= 1'b1;
          r_state      <= r_buf_full ? ST_DATA : ST_IDLE;
        end else begin
          r_bit_cnt    <= r_bit_cnt + CNT_W'(1);
          r_shifter    <= w_shift_next;
          r_serial_out <= w_next_bit;
        end
      end
    end else begin
      r_word_start <= 1'b0;
    end
  end

  assign data_ready   = r_data_ready;
  assign serial_out   = r_serial_out;
  assign word_start   = r_word_start;
  assign sending_data = (r_state == ST_DATA);

endmodule

// File: doc/paralelo_serial_param.md
PARALELO_SERIAL_PARAM -- requirements
Module: paralelo_serial_param

Interface
REQ-001 Parameter WIDTH, default 10: bits per parallel word, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 transmits bit WIDTH-1 first; 0 transmits bit 0 first.
REQ-003 Parameter IDLE_WORD, default 10'h0FA: word transmitted when no data is buffered at a word boundary; WIDTH bits wide.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 enb  input  1  global enable; 0 freezes all state.
REQ-007 bit_tick  input  1  serial bit strobe, one clk cycle wide; replaces the fixed divided bit clock of the previous generation.
REQ-008 data_in  input  WIDTH  parallel word offered by the producer.
REQ-009 data_valid  input  1  data_in holds a word to send.
REQ-010 data_ready  output  1  block can accept a word this cycle.
REQ-011 serial_out  output  1  registered serial bit stream.
REQ-012 word_start  output  1  one-cycle pulse, coincident with serial_out presenting bit 0 of a new word.
REQ-013 sending_data  output  1  1 while the current word is producer data; 0 while it is IDLE_WORD or in OFF.

Function
REQ-014 Holding buffer of one word (buf, buf_full); data_ready SHALL equal ~buf_full, registered.
REQ-015 Accept: on an edge with enb=1, data_valid=1 and data_ready=1, buf<=data_in and buf_full<=1.
REQ-016 Shifter of WIDTH bits plus a bit counter bit_cnt of ceil(log2(WIDTH)) bits.
REQ-017 Edges with enb=1 and bit_tick=0 change only buffer/handshake state; serial_out, shifter and bit_cnt hold.
REQ-018 Edges with enb=1, bit_tick=1 and bit_cnt<WIDTH-1: shifter advances one position toward the output end; bit_cnt increments; serial_out <= next bit.
REQ-019 Word boundary (enb=1, bit_tick=1, bit_cnt==WIDTH-1): bit_cnt<=0; if buf_full, shifter<=buf, buf_full<=0, sending_data<=1; else shifter<=IDLE_WORD, sending_data<=0; serial_out <= first bit of the loaded word in the same edge; word_start<=1.
REQ-020 word_start SHALL be 0 on every edge other than a word boundary.
REQ-021 An accept and a boundary on the same edge cannot both touch buf, since accept requires buf_full=0 and load requires buf_full=1; the implementation shall not add a bypass path.
REQ-022 States: OFF (after reset, before first boundary), IDLE (sending IDLE_WORD), DATA (sending buffered word); OFF->IDLE/DATA at the first boundary; IDLE<->DATA only at boundaries per REQ-019.
REQ-023 enb=0: no state changes, including accept; data_ready, serial_out and sending_data hold; word_start is forced to 0.
REQ-024 bit_tick asserted on consecutive cycles SHALL be legal (one bit per clk).

Reset
REQ-025 rst=0 on an edge takes effect regardless of enb or bit_tick: serial_out=0, word_start=0, sending_data=0, data_ready=1, buf_full=0, bit_cnt=WIDTH-1, shifter=0, state OFF.
REQ-026 Reset asserted mid-word discards the partial word and any buffered word, with no completion of the partial word.
REQ-027 After release, the first bit_tick is a word boundary per REQ-025/REQ-019.

Verification (WIDTH=10, IDLE_WORD=10'h0FA unless noted)
REQ-028 Idle stream, MSB_FIRST=1: rst=0 for 2 cycles, release, bit_tick every cycle, data_valid=0 -> serial_out repeats 0,0,1,1,1,1,1,0,1,0; word_start every 10th cycle; sending_data=0.
REQ-029 Data word: offer 10'h36C mid-idle-word -> data_ready drops next cycle; at the next boundary serial_out = 1,1,0,1,1,0,1,1,0,0 with sending_data=1 and data_ready=1 again; then idle resumes.
REQ-030 Back-to-back: offer 10'h3E0 then 10'h01F on successive ready cycles, bit_tick every 4th cycle -> both words sent with no idle word between them; data_valid is held while data_ready=0 and is not lost.
REQ-031 LSB first: MSB_FIRST=0, send 10'h001 -> serial_out = 1 followed by nine 0s.
REQ-032 Freeze and reset: enb=0 for 7 cycles mid-word with bit_tick toggling -> outputs hold, stream resumes intact afterwards; then rst=0 after bit 4 of 10'h1D5 -> next edge serial_out=0, data_ready=1, and 10'h1D5 is never completed.
REQ-033 Width sweep: WIDTH=8 with IDLE_WORD=8'hBC and WIDTH=16 -> word_start period equals WIDTH ticks and the data bits round-trip through a bench deserializer.
